dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store execution unit directly downstream of the data-cache control decoder in the MEM stage.
- Consumes decoded controls (ren, rwidth, rsign, wen, wwidth) plus address and store data.
- Performs one valid/ready memory-bus transaction per access, with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline until the access completes; flags misaligned accesses without touching the bus.

Parameters:
- ADDR_W, 32, byte-address width; bus address is word-aligned (low 2 bits forced 0).
- DATA_W, 32, data width; only 32 is legal (4 byte lanes).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ren  in  1  load request from decoder
- rwidth  in  3  load width in bytes: 1, 2 or 4
- rsign  in  1  1 = sign-extend load, 0 = zero-extend
- wen  in  1  store request from decoder
- wwidth  in  3  store width in bytes: 1, 2 or 4
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-justified
- stall  out  1  hold MEM stage and upstream
- rdata  out  DATA_W  formatted load result
- rdata_valid  out  1  rdata valid this cycle
- misalign  out  1  misaligned access; combinational
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_we  out  1  1 = write
- bus_req_addr  out  ADDR_W  word-aligned address
- bus_req_wstrb  out  4  byte-lane write strobes; 0 for reads
- bus_req_wdata  out  DATA_W  lane-replicated store data
- bus_resp_valid  in  1  response or write acknowledge
- bus_resp_rdata  in  DATA_W  raw read word

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - All outputs 0, including bus_req_valid, stall, rdata and rdata_valid.
  - Captured registers cleared.
  - Reset mid-transaction abandons the transaction; any later bus_resp_valid seen in IDLE is ignored.
- Request decode:
  - req = ren | wen; if both are set, ren wins.
  - Effective width = rwidth for loads, wwidth for stores.
  - Width values other than 1, 2, 4 make the request a no-op: no stall, no bus access, misalign=0.
- Misalignment:
  - misalign = req & ((width==2 & addr[0]) | (width==4 & addr[1:0]!=0)).
  - Evaluated only in IDLE.
  - A misaligned request causes no bus access and no stall; rdata_valid=0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on an aligned legal req, register op, addr, formatted wdata/wstrb and rsign, then go to REQ. stall=1 combinationally in that cycle.
  - REQ: bus_req_valid=1; all bus_req_* come from registers and stay stable until bus_req_ready. On ready, go to WAIT. stall=1.
  - WAIT: stall=1. On bus_resp_valid, register formatted load data (or 0 for stores) and go to DONE. Responses are never accepted in the same cycle as request acceptance.
  - DONE: stall=0; rdata_valid=1 for loads only; rdata holds its value; return to IDLE next cycle.
- Stall: stall = (IDLE & aligned legal req) | REQ | WAIT.
  - Minimum stall is 3 cycles when ready and response arrive immediately.
- Store formatting (lane = addr[1:0]):
  - Byte: wdata = 4 copies of wdata[7:0]; wstrb = 0001 << lane.
  - Half: wdata = 2 copies of wdata[15:0]; wstrb = 0011 << lane.
  - Word: wdata unchanged; wstrb = 1111.
- Load formatting:
  - word = bus_resp_rdata >> (8*lane).
  - Width 1: extend word[7:0]; width 2: extend word[15:0]; extension per captured rsign.
  - Width 4: word unchanged.
- Ignore rules:
  - In DONE, the next request is not sampled; it is taken on the following IDLE cycle.
  - Input changes during REQ or WAIT are ignored (pipeline is stalled).

Decomposition:
- Shared package lsu_pkg holds:
  - Width encodings: W_BYTE=1, W_HALF=2, W_WORD=4.
  - State enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - Lane-count constant 4.
- One combinational sub-module, lsu_align:
  - Store path: lane replication and strobe generation.
  - Load path: extract and sign/zero extension.
  - Used by the FSM in both directions.

Test Plan:
- Load byte signed: addr=0x1003, rwidth=1, rsign=1, resp rdata=0x80AA_BBCC → bus addr 0x1000, wstrb=0, rdata=0xFFFF_FF80, stall exactly 3 cycles with ready and resp immediate.
- Load half unsigned: addr=0x2002, rwidth=2, rsign=0, resp 0x8001_1234 → rdata=0x0000_8001, rdata_valid pulses 1 cycle.
- Store byte: addr=0x3001, wdata=0x0000_00A5 → bus_req_wdata=0xA5A5_A5A5, wstrb=0010, we=1, held stable across 3 cycles of bus_req_ready=0.
- Misaligned word: wen=1, wwidth=4, addr=0x4002 → misalign=1, stall=0, bus_req_valid never asserted.
- Backpressure/latency: load word at 0x5000, ready delayed 2 cycles, resp delayed 4 → stall held 1+3+4 cycles, then rdata = resp word.
- Reset mid-WAIT: deassert rst_n during WAIT, then pulse bus_resp_valid after release → state IDLE, all outputs 0, stray response ignored, next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the MEM-stage load/store unit.
package lsu_pkg;

   localparam int unsigned LANES      = 4;
   localparam int unsigned LSU_DATA_W = 32;

   // Access width encodings, in bytes
   localparam logic [2:0] W_BYTE = 3'd1;
   localparam logic [2:0] W_HALF = 3'd2;
   localparam logic [2:0] W_WORD = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // Only 1, 2 and 4 byte accesses reach the bus; anything else is a no-op
   function automatic logic width_legal(input logic [2:0] w);
      return (w == W_BYTE) || (w == W_HALF) || (w == W_WORD);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store replication/strobes and load extract/extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]            i_st_width,
   input  logic [1:0]            i_st_lane,
   input  logic [LSU_DATA_W-1:0] i_st_data,
   output logic [LSU_DATA_W-1:0] o_st_data_c,
   output logic [LANES-1:0]      o_st_strb_c,
   input  logic [2:0]            i_ld_width,
   input  logic [1:0]            i_ld_lane,
   input  logic                  i_ld_sign,
   input  logic [LSU_DATA_W-1:0] i_ld_word,
   output logic [LSU_DATA_W-1:0] o_ld_data_c
);

   logic [LSU_DATA_W-1:0] w_shifted;

   // Store path: replicate the right-justified datum across every lane it may land in
   always_comb begin
      o_st_data_c = i_st_data;
      o_st_strb_c = '0;
      case (i_st_width)
         W_BYTE: begin
            o_st_data_c = {4{i_st_data[7:0]}};
            o_st_strb_c = 4'b0001 << i_st_lane;
         end
         W_HALF: begin
            o_st_data_c = {2{i_st_data[15:0]}};
            o_st_strb_c = 4'b0011 << i_st_lane;
         end
         W_WORD: begin
            o_st_strb_c = 4'b1111;
         end
         default: ;
      endcase
   end

   assign w_shifted = i_ld_word >> {i_ld_lane, 3'b000};

   // Load path: bring the addressed lane down to bit 0, then sign/zero extend
   always_comb begin
      o_ld_data_c = w_shifted;
      case (i_ld_width)
         W_BYTE:  o_ld_data_c = {{24{i_ld_sign & w_shifted[7]}}, w_shifted[7:0]};
         W_HALF:  o_ld_data_c = {{16{i_ld_sign & w_shifted[15]}}, w_shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per aligned access.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ren,
   input  logic [2:0]        rwidth,
   input  logic              rsign,
   input  logic              wen,
   input  logic [2:0]        wwidth,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              misalign,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_req_we,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic [3:0]        bus_req_wstrb,
   output logic [DATA_W-1:0] bus_req_wdata,
   input  logic              bus_resp_valid,
   input  logic [DATA_W-1:0] bus_resp_rdata
);

   lsu_state_t r_state;
   lsu_state_t w_next;

   logic              r_req_valid;
   logic              r_we;
   logic              r_rsign;
   logic              r_rdata_valid;
   logic [2:0]        r_width;
   logic [1:0]        r_lane;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [LANES-1:0]  r_wstrb;

   logic              w_req;
   logic [2:0]        w_width;
   logic              w_mis;
   logic              w_start;
   logic [DATA_W-1:0] w_st_data;
   logic [DATA_W-1:0] w_ld_data;
   logic [LANES-1:0]  w_st_strb;

   // Request decode: loads win over stores when both are raised
   assign w_req   = ren | wen;
   assign w_width = ren ? rwidth : wwidth;
   assign w_mis   = w_req & (((w_width == W_HALF) & addr[0]) |
                             ((w_width == W_WORD) & (addr[1:0] != 2'b00)));
   assign w_start = (r_state == IDLE) & w_req & width_legal(w_width) & ~w_mis;

   // Store formatting uses live inputs; load formatting uses captured access info
   lsu_align u_align (
      .i_st_width  (w_width),
      .i_st_lane   (addr[1:0]),
      .i_st_data   (wdata),
      .o_st_data_c (w_st_data),
      .o_st_strb_c (w_st_strb),
      .i_ld_width  (r_width),
      .i_ld_lane   (r_lane),
      .i_ld_sign   (r_rsign),
      .i_ld_word   (bus_resp_rdata),
      .o_ld_data_c (w_ld_data)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state plus the combinational stall/misalign flags
   always_comb begin
      w_next   = r_state;
      stall    = 1'b0;
      misalign = 1'b0;
      case (r_state)
         IDLE: begin
            misalign = w_mis;
            stall    = w_start;
            if (w_start) w_next = REQ;
         end
         REQ: begin
            stall = 1'b1;
            if (bus_req_ready) w_next = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (bus_resp_valid) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Capture the access on start, drop valid on handshake, latch the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_valid   <= 1'b0;
         r_we          <= 1'b0;
         r_rsign       <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_width       <= '0;
         r_lane        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rdata       <= '0;
         r_wstrb       <= '0;
      end else begin
         r_rdata_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_req_valid <= 1'b1;
                  r_we        <= ~ren;
                  r_addr      <= {addr[ADDR_W-1:2], 2'b00};
                  r_wdata     <= ren ? '0 : w_st_data;
                  r_wstrb     <= ren ? '0 : w_st_strb;
                  r_rsign     <= rsign;
                  r_width     <= w_width;
                  r_lane      <= addr[1:0];
               end
            end
            REQ: begin
               if (bus_req_ready) r_req_valid <= 1'b0;
            end
            WAIT: begin
               if (bus_resp_valid) begin
                  r_rdata       <= r_we ? '0 : w_ld_data;
                  r_rdata_valid <= ~r_we;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req_valid = r_req_valid;
   assign bus_req_we    = r_we;
   assign bus_req_addr  = r_addr;
   assign bus_req_wstrb = r_wstrb;
   assign bus_req_wdata = r_wdata;
   assign rdata         = r_rdata;
   assign rdata_valid   = r_rdata_valid;

endmodule
